// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, command codes and build defaults.
package uart_pkg;

    localparam int PREDIV_W_DEF  = 8;
    localparam int DATA_BITS_DEF = 8;

    localparam logic [1:0] CMD_DATA   = 2'b00;
    localparam logic [1:0] CMD_CONFIG = 2'b01;
    localparam logic [1:0] CMD_PREDIV = 2'b10;
    localparam logic [1:0] CMD_SPARE  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } tx_state_t;

endpackage

// File: rtl/uart_tx_framer_if.sv
// Byte handshake into the UART transmitter: the producer drives data/valid, the framer drives ready.
interface uart_tx_framer_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
);
    logic [DATA_BITS-1:0] io_data;
    logic                 io_valid;
    logic                 io_ready;

    modport master (output io_data, output io_valid, input io_ready);
    modport slave  (input io_data, input io_valid, output io_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts prediv..0, pulses bit_end on zero and reloads; shared by TX and RX.
module uart_baud_gen #(
    parameter int PREDIV_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PREDIV_W-1:0] prediv,
    input  logic                load,
    input  logic                run,
    output logic                bit_end
);
    logic [PREDIV_W-1:0] cnt_reg;

    // bit_end must not depend on load: the framer derives load from bit_end at end of frame.
    assign bit_end = run && (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= prediv;
        end else if (run) begin
            if (cnt_reg == '0) begin
                cnt_reg <= prediv;
            end else begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: one-deep holding register feeding an LSB-first serialiser (start, data, stop).
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd when io_parity_odd=1) after the data.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int PREDIV_W  = PREDIV_W_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PREDIV_W-1:0] io_prediv,
    input  logic                io_stop2,
    input  logic                io_parity_odd,
    uart_tx_framer_if.slave     tx,
    output logic                io_txd,
    output logic                io_busy
);
    localparam int IDX_W = $clog2(DATA_BITS);

    tx_state_t            state_reg, state_next;
    logic [DATA_BITS-1:0] hold_reg, hold_next;
    logic                 hold_full_reg, hold_full_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [PREDIV_W-1:0]  prediv_sh_reg, prediv_sh_next;
    logic                 stop2_sh_reg, stop2_sh_next;
    logic                 txd_reg, txd_next;
    logic                 frame_start;
    logic                 frame_end;
    logic                 bit_end;
    logic                 accept;
`ifdef UART_TX_PARITY_EN
    logic                 parity_reg, parity_next;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = io_parity_odd;
`endif

    assign tx.io_ready = !hold_full_reg && !reset;
    assign accept      = tx.io_valid && tx.io_ready;
    assign io_txd      = txd_reg;
    assign io_busy     = (state_reg != IDLE);

    // A new frame loads the counter from the live prescaler; every later bit reloads from the shadow.
    uart_baud_gen #(.PREDIV_W(PREDIV_W)) u_baud (
        .clk     (clk),
        .reset   (reset),
        .prediv  (frame_start ? io_prediv : prediv_sh_reg),
        .load    (frame_start),
        .run     (state_reg != IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            shift_reg     <= '0;
            idx_reg       <= '0;
            prediv_sh_reg <= '0;
            stop2_sh_reg  <= 1'b0;
            txd_reg       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            shift_reg     <= shift_next;
            idx_reg       <= idx_next;
            prediv_sh_reg <= prediv_sh_next;
            stop2_sh_reg  <= stop2_sh_next;
            txd_reg       <= txd_next;
`ifdef UART_TX_PARITY_EN
            parity_reg    <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        shift_next     = shift_reg;
        idx_next       = idx_reg;
        prediv_sh_next = prediv_sh_reg;
        stop2_sh_next  = stop2_sh_reg;
        frame_start    = 1'b0;
        frame_end      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next    = parity_reg;
`endif
        case (state_reg)
            IDLE:   frame_start = hold_full_reg;
            START:  if (bit_end) begin
                        state_next = DATA;
                        idx_next   = '0;
                    end
            DATA:   if (bit_end) begin
                        shift_next = shift_reg >> 1;
                        if (idx_reg == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP1;
`endif
                        end else begin
                            idx_next = idx_reg + 1'b1;
                        end
                    end
            PARITY: if (bit_end) state_next = STOP1;
            STOP1:  if (bit_end) begin
                        if (stop2_sh_reg) state_next = STOP2;
                        else              frame_end  = 1'b1;
                    end
            STOP2:  frame_end = bit_end;
            default: state_next = IDLE;
        endcase

        // A waiting byte chains straight into the next start bit with no idle gap.
        if (frame_end) begin
            if (hold_full_reg) frame_start = 1'b1;
            else               state_next  = IDLE;
        end
        if (frame_start) begin
            state_next     = START;
            shift_next     = hold_reg;
            hold_full_next = 1'b0;
            prediv_sh_next = io_prediv;
            stop2_sh_next  = io_stop2;
`ifdef UART_TX_PARITY_EN
            parity_next    = (^hold_reg) ^ io_parity_odd;
`endif
        end
        if (accept) begin
            hold_next      = tx.io_data;
            hold_full_next = 1'b1;
        end
    end

    // The line level is registered, so it trails the state by one cycle.
    always_comb begin
        txd_next = 1'b1;
        case (state_reg)
            START:  txd_next = 1'b0;
            DATA:   txd_next = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            PARITY: txd_next = parity_reg;
`endif
            default: txd_next = 1'b1;
        endcase
    end
endmodule
